alu_op_arbiter: RTL and testbench

//   Shares the single 2-to-4 ALU-block decoder among NREQ requesters.

---
 rtl/alu_op_arbiter_pkg.sv | 20 ++
 rtl/alu_op_arbiter_if.sv | 29 ++
 rtl/alu_op_arbiter_rr_arbiter.sv | 31 +++
 rtl/alu_op_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_op_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_arbiter_pkg.sv
// Shared types for the ALU-op arbiter: FSM state encoding and ALU op codes.
package alu_op_arbiter_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP0 = 2'd0,
    OP1 = 2'd1,
    OP2 = 2'd2,
    OP3 = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_op_arbiter_if.sv
// Request/op inputs and decoder-control outputs of the ALU-op arbiter.
interface alu_op_arbiter_if
  import alu_op_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req;
  logic [OP_W*NREQ-1:0] op_in;
  logic                 flush;
  logic [NREQ-1:0]      grant;
  logic                 S0;
  logic                 S1;
  logic                 enable;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        done_id;

  modport master (
    output req, op_in, flush,
    input  grant, S0, S1, enable, busy, done, done_id
  );

  modport slave (
    input  req, op_in, flush,
    output grant, S0, S1, enable, busy, done, done_id
  );
endinterface

// File: rtl/alu_op_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning from ptr upward, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh_c,
  output logic [IW-1:0]   win_idx_c,
  output logic            any_c
);

  always_comb begin
    int unsigned j;
    logic        found;
    win_oh_c  = '0;
    win_idx_c = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[IW'(j)]) begin
        win_oh_c[IW'(j)] = 1'b1;
        win_idx_c        = IW'(j);
        found            = 1'b1;
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin owner of the shared 2-to-4 ALU decoder: grants one requester, drives
// {S1,S0}/enable for OP_CYCLES cycles, then pulses done with the winner's index.
module alu_op_arbiter
  import alu_op_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned OP_CYCLES = 3
) (
  input logic             clk,
  input logic             rst,
  alu_op_arbiter_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(OP_CYCLES + 1);

  state_e          state_q, state_d;
  alu_op_e         op_q, op_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [1:0]      sel_q, sel_d;
  logic            enable_q, enable_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IW-1:0]   done_id_q, done_id_d;

  logic [NREQ-1:0] pick_oh_c;
  logic [IW-1:0]   pick_idx_c;
  logic            pick_any_c;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req       (bus.req),
    .ptr       (ptr_q),
    .win_oh_c  (pick_oh_c),
    .win_idx_c (pick_idx_c),
    .any_c     (pick_any_c)
  );

  // Next state and next registered outputs; outputs are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    sel_d     = 2'b00;
    enable_d  = 1'b0;
    done_d    = 1'b0;
    done_id_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          state_d  = ST_ISSUE;
          op_d     = alu_op_e'(bus.op_in[{pick_idx_c, 1'b0} +: OP_W]);
          win_d    = pick_idx_c;
          cnt_d    = CW'(1);
          grant_d  = pick_oh_c;
          enable_d = 1'b1;
          sel_d    = op_d;
        end
      end
      ST_ISSUE: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (OP_CYCLES > 1) begin
          state_d  = ST_BUSY;
          cnt_d    = CW'(2);
          enable_d = 1'b1;
          sel_d    = op_q;
        end else begin
          state_d   = ST_DONE;
          sel_d     = op_q;
          done_d    = 1'b1;
          done_id_d = win_q;
        end
      end
      ST_BUSY: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(OP_CYCLES)) begin
          state_d   = ST_DONE;
          sel_d     = op_q;
          done_d    = 1'b1;
          done_id_d = win_q;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          enable_d = 1'b1;
          sel_d    = op_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP0;
      win_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      sel_q     <= 2'b00;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.S0      = sel_q[0];
  assign bus.S1      = sel_q[1];
  assign bus.enable  = enable_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Self-checking bench for alu_op_arbiter: transaction-level round-robin model, directed and random scenarios.
module tb_alu_op_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned OPC  = 3;
  localparam int unsigned IW   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_op_arbiter #(.NREQ(NREQ), .OP_CYCLES(OPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  // Spec rule: first set request scanning ptr, ptr+1, ... mod NREQ.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    logic [IW-1:0] k;
    for (int i = 0; i < NREQ; i++) begin
      k = IW'((p + i) % NREQ);
      if (r[k]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // One complete transaction starting from IDLE with req already driven.
  task automatic do_op(input bit drop, input logic [NREQ-1:0] add_req, input bit set_ops,
                       input logic [2*NREQ-1:0] ops, output int gap);
    int w;
    logic [1:0] op;
    logic [3:0] y;
    int n;
    bit ok;
    w   = rr_pick(bus.req, model_ptr);
    op  = 2'(bus.op_in >> (2 * w));
    gap = 0;
    ok  = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      gap++;
      if (bus.grant != '0) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout: no grant within 20 cycles, required requester %0d", w);
      return;
    end
    checks++;
    if (bus.grant !== NREQ'(1 << w)) begin
      errors++;
      $display("FAIL grant: got %b required %b", bus.grant, NREQ'(1 << w));
    end
    y = bus.enable ? 4'(1 << {bus.S1, bus.S0}) : 4'b0;
    checks++;
    if ({bus.busy, bus.done, y} !== {1'b1, 1'b0, 4'(1 << op)}) begin
      errors++;
      $display("FAIL issue: busy=%b done=%b y=%b required busy=1 done=0 y=%b", bus.busy, bus.done, y, 4'(1 << op));
    end
    if (drop) bus.req = bus.req & ~NREQ'(1 << w);
    n = 1;
    for (int c = 0; c < OPC + 4; c++) begin
      @(negedge clk);
      if (!bus.enable) break;
      n++;
      checks++;
      if ({bus.S1, bus.S0, bus.grant, bus.done, bus.busy} !== {op, NREQ'(0), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL hold: sel=%b grant=%b done=%b busy=%b required sel=%b grant=0 done=0 busy=1",
                 {bus.S1, bus.S0}, bus.grant, bus.done, bus.busy, op);
      end
      if (n == 2) begin
        bus.req = bus.req | add_req;
        if (set_ops) bus.op_in = ops;
      end
    end
    checks++;
    if (n != OPC) begin
      errors++;
      $display("FAIL enable_len: got %0d cycles required %0d", n, OPC);
    end
    checks++;
    if ({bus.done, bus.done_id, bus.S1, bus.S0, bus.busy, bus.grant} !== {1'b1, IW'(w), op, 1'b1, NREQ'(0)}) begin
      errors++;
      $display("FAIL done: done=%b id=%0d sel=%b busy=%b required done=1 id=%0d sel=%b busy=1",
               bus.done, bus.done_id, {bus.S1, bus.S0}, bus.busy, w, op);
    end
    model_ptr = (w + 1) % NREQ;
    @(negedge clk);
    checks++;
    if ({bus.grant, bus.enable, bus.busy, bus.done, bus.S1, bus.S0, bus.done_id} !== '0) begin
      errors++;
      $display("FAIL idle_after_done: grant=%b en=%b busy=%b done=%b sel=%b id=%0d required all 0",
               bus.grant, bus.enable, bus.busy, bus.done, {bus.S1, bus.S0}, bus.done_id);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.op_in = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.grant, bus.enable, bus.busy, bus.done, bus.S1, bus.S0, bus.done_id} !== '0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d grant=%b en=%b busy=%b done=%b required all 0",
                 i, bus.grant, bus.enable, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_single();
    int gap;
    bus.req   = 4'b0001;
    bus.op_in = 8'b0000_0010;
    do_op(1'b1, '0, 1'b0, '0, gap);
    checks++;
    if (gap != 1) begin
      errors++;
      $display("FAIL single_latency: grant after %0d cycles required 1", gap);
    end
  endtask

  task automatic test_round_robin();
    int gap;
    int seq[5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    bus.req   = 4'b1111;
    bus.op_in = {2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rr_pick(bus.req, model_ptr) != seq[i]) begin
        errors++;
        $display("FAIL rr_model: op %0d model winner %0d required %0d", i, rr_pick(bus.req, model_ptr), seq[i]);
      end
      do_op(1'b0, '0, 1'b0, '0, gap);
      checks++;
      if (gap != 1) begin
        errors++;
        $display("FAIL rr_spacing: op %0d gap %0d required 1 (5-cycle period)", i, gap);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_late_req();
    int gap;
    bus.req   = 4'b0001;
    bus.op_in = 8'b0000_0001;
    do_op(1'b1, 4'b0100, 1'b1, 8'b0011_0010, gap);
    do_op(1'b1, '0, 1'b0, '0, gap);
    checks++;
    if (gap != 1) begin
      errors++;
      $display("FAIL late_req_gap: gap %0d required 1", gap);
    end
    bus.req = '0;
  endtask

  task automatic test_flush();
    int w;
    int gap;
    bit ok;
    bus.req   = 4'b1101;
    bus.op_in = 8'($urandom);
    w  = rr_pick(bus.req, model_ptr);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.grant != '0) ok = 1;
    end
    checks++;
    if (!ok || bus.grant !== NREQ'(1 << w)) begin
      errors++;
      $display("FAIL flush_grant: got %b required %b", bus.grant, NREQ'(1 << w));
    end
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if ({bus.enable, bus.busy, bus.done, bus.grant} !== '0) begin
      errors++;
      $display("FAIL flush_abort: en=%b busy=%b done=%b grant=%b required all 0",
               bus.enable, bus.busy, bus.done, bus.grant);
    end
    do_op(1'b1, '0, 1'b0, '0, gap);
    checks++;
    if (gap != 1) begin
      errors++;
      $display("FAIL flush_rearb: gap %0d required 1", gap);
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    int gap;
    bit ok;
    bus.req = 4'b0010;
    do_op(1'b1, '0, 1'b0, '0, gap);
    bus.req = 4'b0100;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.grant != '0) ok = 1;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!ok || {bus.enable, bus.busy, bus.grant, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_mid: started=%0d en=%b busy=%b grant=%b done=%b required all 0",
               ok, bus.enable, bus.busy, bus.grant, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    bus.req = 4'b1111;
    do_op(1'b1, '0, 1'b0, '0, gap);
    bus.req = '0;
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 30; i++) begin
      if (bus.req == '0) begin
        bus.req   = NREQ'($urandom_range(1, 15));
        bus.op_in = 8'($urandom);
      end
      do_op(1'($urandom), NREQ'($urandom), 1'b1, 8'($urandom), gap);
    end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_late_req();
    test_flush();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
